psum_adder_sched: RTL and testbench



---
 rtl/snn_noc_pkg.sv | 39 +++
 rtl/psum_capture.sv | 61 ++++++
 rtl/psum_adder_sched.sv | 122 ++++++++++++
 tb/tb_psum_adder_sched.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_noc_pkg.sv
// Shared NoC/scheduler definitions for the SNN partial-sum path: widths, PE
// source addresses, scheduler states and the source-to-slot decoder.
package snn_noc_pkg;

    localparam int PSUM_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int NUM_POS  = 3;
    localparam int NUM_MAPS = 4;
    localparam int POS_W    = 2;
    localparam int MAP_W    = $clog2(NUM_MAPS);

    localparam logic [ADDR_W-1:0] PE1_ADDR = 4'b0100;
    localparam logic [ADDR_W-1:0] PE2_ADDR = 4'b0101;
    localparam logic [ADDR_W-1:0] PE3_ADDR = 4'b0001;

    typedef enum logic [1:0] {
        ST_COLLECT    = 2'd0,
        ST_FETCH_REQ  = 2'd1,
        ST_FETCH_WAIT = 2'd2,
        ST_DISPATCH   = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] slot;
    } slot_sel_t;

    function automatic slot_sel_t src_to_slot(input logic [ADDR_W-1:0] src);
        slot_sel_t sel;
        case (src)
            PE1_ADDR: begin sel.valid = 1'b1; sel.slot = 2'd0; end
            PE2_ADDR: begin sel.valid = 1'b1; sel.slot = 2'd1; end
            PE3_ADDR: begin sel.valid = 1'b1; sel.slot = 2'd2; end
            default:  begin sel.valid = 1'b0; sel.slot = 2'd0; end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/psum_capture.sv
// Collects one partial sum per PE slot; a slot already filled back-pressures
// further packets from the same PE until the scheduler clears the set.
module psum_capture
    import snn_noc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                collect_en,
    input  logic                clear,
    input  logic                pkt_valid,
    input  logic [ADDR_W-1:0]   pkt_src,
    input  logic [PSUM_W-1:0]   pkt_data,
    output logic                pkt_ready,
    output logic                known_hs,
    output logic                unknown_hs,
    output logic                complete,
    output logic [3*PSUM_W-1:0] psum
);

    slot_sel_t                   sel_s;
    logic [2:0]                  onehot_s;
    logic [2:0]                  mask_r;
    logic [2:0][PSUM_W-1:0]      psum_r;

    // Decode source, ready/handshake qualification and completion of the set
    always_comb begin
        sel_s      = src_to_slot(pkt_src);
        onehot_s   = 3'b001 << sel_s.slot;
        pkt_ready  = 1'b0;
        if (!collect_en) begin
            pkt_ready = 1'b0;
        end else if (!sel_s.valid) begin
            pkt_ready = 1'b1;
        end else begin
            pkt_ready = !mask_r[sel_s.slot];
        end
        known_hs   = pkt_valid && pkt_ready && sel_s.valid;
        unknown_hs = pkt_valid && pkt_ready && !sel_s.valid;
        if (known_hs) begin
            complete = ((mask_r | onehot_s) == 3'b111);
        end else begin
            complete = (mask_r == 3'b111);
        end
    end

    // Slot mask and partial-sum storage
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r <= 3'b000;
            psum_r <= '0;
        end else if (clear) begin
            mask_r <= 3'b000;
        end else if (known_hs) begin
            mask_r              <= mask_r | onehot_s;
            psum_r[sel_s.slot]  <= pkt_data;
        end
    end

    assign psum = psum_r;

endmodule

// File: rtl/psum_adder_sched.sv
// Scheduler in front of the partial-sum adder: gathers three PE partial sums,
// fetches the stored membrane potential after the first map, issues one add.
module psum_adder_sched
    import snn_noc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                pkt_valid,
    output logic                pkt_ready,
    input  logic [ADDR_W-1:0]   pkt_src,
    input  logic [PSUM_W-1:0]   pkt_data,
    output logic                mp_req_valid,
    input  logic                mp_req_ready,
    output logic [1:0]          mp_req_pos,
    input  logic                mp_rsp_valid,
    input  logic [PSUM_W-1:0]   mp_rsp_data,
    output logic                add_valid,
    input  logic                add_ready,
    output logic [3*PSUM_W-1:0] add_psum,
    output logic [PSUM_W-1:0]   add_mp,
    output logic                add_first,
    output logic [1:0]          add_pos,
    output logic                frame_done,
    output logic                err_src
);

    sched_state_t        state_r;
    logic [POS_W-1:0]    pos_r;
    logic [MAP_W-1:0]    map_r;
    logic [PSUM_W-1:0]   add_mp_r;
    logic                frame_done_r;
    logic                err_src_r;

    logic                collect_en_s;
    logic                add_hs_s;
    logic                known_hs_s;
    logic                unknown_hs_s;
    logic                complete_s;
    logic                last_pos_s;
    logic                last_map_s;

    assign collect_en_s = (state_r == ST_COLLECT);
    assign add_hs_s     = (state_r == ST_DISPATCH) && add_ready;
    assign last_pos_s   = (pos_r == POS_W'(NUM_POS - 1));
    assign last_map_s   = (map_r == MAP_W'(NUM_MAPS - 1));

    psum_capture u_capture (
        .clk        (clk),
        .reset      (reset),
        .collect_en (collect_en_s),
        .clear      (add_hs_s),
        .pkt_valid  (pkt_valid),
        .pkt_src    (pkt_src),
        .pkt_data   (pkt_data),
        .pkt_ready  (pkt_ready),
        .known_hs   (known_hs_s),
        .unknown_hs (unknown_hs_s),
        .complete   (complete_s),
        .psum       (add_psum)
    );

    // Scheduler FSM, position/map tracking and pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_COLLECT;
            pos_r        <= '0;
            map_r        <= '0;
            add_mp_r     <= '0;
            frame_done_r <= 1'b0;
            err_src_r    <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            err_src_r    <= unknown_hs_s;
            case (state_r)
                ST_COLLECT: begin
                    if (complete_s) begin
                        if (map_r != '0) begin
                            state_r <= ST_FETCH_REQ;
                        end else begin
                            state_r  <= ST_DISPATCH;
                            add_mp_r <= '0;
                        end
                    end
                end
                ST_FETCH_REQ: begin
                    if (mp_req_ready) begin
                        state_r <= ST_FETCH_WAIT;
                    end
                end
                ST_FETCH_WAIT: begin
                    if (mp_rsp_valid) begin
                        add_mp_r <= mp_rsp_data;
                        state_r  <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (add_ready) begin
                        state_r <= ST_COLLECT;
                        if (last_pos_s) begin
                            pos_r        <= '0;
                            map_r        <= last_map_s ? '0 : map_r + MAP_W'(1);
                            frame_done_r <= last_map_s;
                        end else begin
                            pos_r <= pos_r + POS_W'(1);
                        end
                    end
                end
                default: state_r <= ST_COLLECT;
            endcase
        end
    end

    assign mp_req_valid = (state_r == ST_FETCH_REQ);
    assign mp_req_pos   = pos_r;
    assign add_valid    = (state_r == ST_DISPATCH);
    assign add_mp       = add_mp_r;
    assign add_first    = (map_r == '0);
    assign add_pos      = pos_r;
    assign frame_done   = frame_done_r;
    assign err_src      = err_src_r;

endmodule

// File: tb/tb_psum_adder_sched.sv
// Directed bench for psum_adder_sched; inputs change and outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_psum_adder_sched;

    localparam logic [3:0] PE1 = 4'b0100;
    localparam logic [3:0] PE2 = 4'b0101;
    localparam logic [3:0] PE3 = 4'b0001;

    logic        clk;
    logic        reset;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_src;
    logic [7:0]  pkt_data;
    logic        mp_req_valid;
    logic        mp_req_ready;
    logic [1:0]  mp_req_pos;
    logic        mp_rsp_valid;
    logic [7:0]  mp_rsp_data;
    logic        add_valid;
    logic        add_ready;
    logic [23:0] add_psum;
    logic [7:0]  add_mp;
    logic        add_first;
    logic [1:0]  add_pos;
    logic        frame_done;
    logic        err_src;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;

    psum_adder_sched dut (
        .clk          (clk),
        .reset        (reset),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_src      (pkt_src),
        .pkt_data     (pkt_data),
        .mp_req_valid (mp_req_valid),
        .mp_req_ready (mp_req_ready),
        .mp_req_pos   (mp_req_pos),
        .mp_rsp_valid (mp_rsp_valid),
        .mp_rsp_data  (mp_rsp_data),
        .add_valid    (add_valid),
        .add_ready    (add_ready),
        .add_psum     (add_psum),
        .add_mp       (add_mp),
        .add_first    (add_first),
        .add_pos      (add_pos),
        .frame_done   (frame_done),
        .err_src      (err_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    // Called on a falling edge; returns on the falling edge after the handshake.
    task automatic send_pkt(input logic [3:0] src, input logic [7:0] d);
        int n = 0;
        pkt_valid = 1'b1; pkt_src = src; pkt_data = d;
        #1;
        while (!pkt_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (pkt_ready !== 1'b1) begin
            errors++;
            $display("FAIL pkt_accept_timeout: src=%b ready=%b required 1", src, pkt_ready);
        end
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [7:0] rsp);
        int n = 0;
        while (!mp_req_valid && n < 50) begin
            @(negedge clk); n++;
        end
        checks++;
        if (mp_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL mp_req_timeout: mp_req_valid=%b required 1", mp_req_valid);
        end
        mp_req_ready = 1'b1;
        @(negedge clk);
        mp_req_ready = 1'b0;
        mp_rsp_valid = 1'b1; mp_rsp_data = rsp;
        @(negedge clk);
        mp_rsp_valid = 1'b0;
    endtask

    task automatic do_cmd();
        int n = 0;
        while (!add_valid && n < 50) begin
            @(negedge clk); n++;
        end
        checks++;
        if (add_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_timeout: add_valid=%b required 1", add_valid);
        end
        add_ready = 1'b1;
        @(negedge clk);
        add_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mp_req_valid, add_valid, frame_done, err_src} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valids: got %b required 0000", {mp_req_valid, add_valid, frame_done, err_src});
        end
        checks++;
        if ({add_psum, add_mp} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {add_psum, add_mp});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({pkt_ready, add_pos, add_first} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_collect: got ready/pos/first=%b required 1001", {pkt_ready, add_pos, add_first});
        end
    endtask

    task automatic test_map0_in_order();
        send_pkt(PE1, 8'd5);
        send_pkt(PE2, 8'd3);
        send_pkt(PE3, 8'd2);
        checks++;
        if (add_valid !== 1'b1 || mp_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL map0_latency: add_valid=%b mp_req_valid=%b required 1 0", add_valid, mp_req_valid);
        end
        checks++;
        if (add_psum !== {8'd2, 8'd3, 8'd5}) begin
            errors++;
            $display("FAIL map0_psum: got %h required 020305", add_psum);
        end
        checks++;
        if ({add_mp, add_first, add_pos} !== {8'd0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL map0_fields: mp=%0d first=%b pos=%0d required 0 1 0", add_mp, add_first, add_pos);
        end
        do_cmd();
        checks++;
        if (add_valid !== 1'b0) begin
            errors++;
            $display("FAIL map0_drop_valid: add_valid=%b required 0", add_valid);
        end
    endtask

    task automatic test_duplicate();
        send_pkt(PE3, 8'd9);
        pkt_valid = 1'b1; pkt_src = PE3; pkt_data = 8'd11;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (pkt_ready !== 1'b0) begin
            errors++;
            $display("FAIL dup_backpressure: pkt_ready=%b required 0", pkt_ready);
        end
        pkt_valid = 1'b0;
        @(negedge clk);
        send_pkt(PE1, 8'd4);
        send_pkt(PE2, 8'd6);
        checks++;
        if (add_psum !== {8'd9, 8'd6, 8'd4} || add_pos !== 2'd1) begin
            errors++;
            $display("FAIL dup_first_kept: psum=%h pos=%0d required 090604 1", add_psum, add_pos);
        end
        pkt_valid = 1'b1; pkt_src = PE3; pkt_data = 8'd11;
        #1;
        checks++;
        if (pkt_ready !== 1'b0) begin
            errors++;
            $display("FAIL dup_dispatch_ready: pkt_ready=%b required 0", pkt_ready);
        end
        @(negedge clk);
        add_ready = 1'b1;
        @(negedge clk);
        add_ready = 1'b0;
        checks++;
        if (pkt_ready !== 1'b1) begin
            errors++;
            $display("FAIL dup_released: pkt_ready=%b required 1", pkt_ready);
        end
        @(negedge clk);
        pkt_valid = 1'b0;
        send_pkt(PE1, 8'd1);
        send_pkt(PE2, 8'd2);
        checks++;
        if (add_psum !== {8'd11, 8'd2, 8'd1} || add_pos !== 2'd2 || add_first !== 1'b1) begin
            errors++;
            $display("FAIL dup_next_pos: psum=%h pos=%0d first=%b required 0b0201 2 1", add_psum, add_pos, add_first);
        end
        do_cmd();
    endtask

    task automatic test_add_stall();
        send_pkt(PE1, 8'd10);
        send_pkt(PE2, 8'd20);
        send_pkt(PE3, 8'd30);
        checks++;
        if (mp_req_valid !== 1'b1 || mp_req_pos !== 2'd0 || add_valid !== 1'b0) begin
            errors++;
            $display("FAIL map1_req: req=%b pos=%0d add_valid=%b required 1 0 0", mp_req_valid, mp_req_pos, add_valid);
        end
        do_fetch(8'd50);
        pkt_src = PE1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (add_valid !== 1'b1 || add_psum !== {8'd30, 8'd20, 8'd10} || add_mp !== 8'd50
                || add_pos !== 2'd0 || add_first !== 1'b0 || pkt_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_stable[%0d]: v=%b psum=%h mp=%0d pos=%0d first=%b rdy=%b required 1 1e140a 50 0 0 0",
                         i, add_valid, add_psum, add_mp, add_pos, add_first, pkt_ready);
            end
            @(negedge clk);
        end
        do_cmd();
    endtask

    task automatic test_unknown_src();
        send_pkt(4'b1111, 8'hAA);
        checks++;
        if (err_src !== 1'b1) begin
            errors++;
            $display("FAIL err_src_pulse: err_src=%b required 1", err_src);
        end
        pkt_src = PE1;
        #1;
        checks++;
        if (pkt_ready !== 1'b1 || add_valid !== 1'b0 || mp_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_mask_kept: rdy=%b add_valid=%b req=%b required 1 0 0", pkt_ready, add_valid, mp_req_valid);
        end
        @(negedge clk);
        checks++;
        if (err_src !== 1'b0) begin
            errors++;
            $display("FAIL err_src_once: err_src=%b required 0", err_src);
        end
        send_pkt(PE1, 8'd7);
        send_pkt(PE2, 8'd8);
        send_pkt(PE3, 8'd9);
        do_fetch(8'd3);
        checks++;
        if (add_pos !== 2'd1 || add_mp !== 8'd3 || add_psum !== {8'd9, 8'd8, 8'd7}) begin
            errors++;
            $display("FAIL pos_once: pos=%0d mp=%0d psum=%h required 1 3 090807", add_pos, add_mp, add_psum);
        end
        do_cmd();
    endtask

    task automatic test_fetch_delay();
        send_pkt(PE2, 8'd33);
        send_pkt(PE1, 8'd44);
        send_pkt(PE3, 8'd22);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mp_req_valid !== 1'b1 || mp_req_pos !== 2'd2) begin
                errors++;
                $display("FAIL req_held[%0d]: req=%b pos=%0d required 1 2", i, mp_req_valid, mp_req_pos);
            end
            @(negedge clk);
        end
        mp_req_ready = 1'b1;
        @(negedge clk);
        mp_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mp_req_valid !== 1'b0 || add_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: req=%b add_valid=%b required 0 0", mp_req_valid, add_valid);
        end
        mp_rsp_valid = 1'b1; mp_rsp_data = 8'd7;
        @(negedge clk);
        mp_rsp_valid = 1'b0;
        checks++;
        if (add_valid !== 1'b1 || add_mp !== 8'd7 || add_first !== 1'b0 || add_pos !== 2'd2
            || add_psum !== {8'd22, 8'd33, 8'd44}) begin
            errors++;
            $display("FAIL fetch_cmd: v=%b mp=%0d first=%b pos=%0d psum=%h required 1 7 0 2 16212c",
                     add_valid, add_mp, add_first, add_pos, add_psum);
        end
        do_cmd();
    endtask

    task automatic test_frame();
        logic [7:0] e1, e2, e3, er;
        for (int m = 2; m < 4; m++) begin
            for (int p = 0; p < 3; p++) begin
                e1 = 8'(m * 16 + p * 4 + 1);
                e2 = 8'(m * 16 + p * 4 + 2);
                e3 = 8'(m * 16 + p * 4 + 3);
                er = 8'(m * 10 + p);
                send_pkt(PE3, e3);
                send_pkt(PE1, e1);
                send_pkt(PE2, e2);
                do_fetch(er);
                checks++;
                if (add_psum !== {e3, e2, e1} || add_mp !== er || add_pos !== 2'(p) || add_first !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_cmd m%0d p%0d: psum=%h mp=%0d pos=%0d first=%b required %h %0d %0d 0",
                             m, p, add_psum, add_mp, add_pos, add_first, {e3, e2, e1}, er, p);
                end
                do_cmd();
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_pulse: frame_done=%b required 1", frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || fd_cnt !== 1) begin
            errors++;
            $display("FAIL frame_done_once: frame_done=%b count=%0d required 0 1", frame_done, fd_cnt);
        end
        send_pkt(PE1, 8'd1);
        send_pkt(PE2, 8'd1);
        send_pkt(PE3, 8'd1);
        checks++;
        if (add_valid !== 1'b1 || add_first !== 1'b1 || add_pos !== 2'd0 || mp_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_wrap: v=%b first=%b pos=%0d req=%b required 1 1 0 0", add_valid, add_first, add_pos, mp_req_valid);
        end
        do_cmd();
    endtask

    task automatic test_reset_fetch_wait();
        for (int p = 1; p < 3; p++) begin
            send_pkt(PE1, 8'd0);
            send_pkt(PE2, 8'd0);
            send_pkt(PE3, 8'd0);
            do_cmd();
        end
        send_pkt(PE1, 8'd5);
        send_pkt(PE2, 8'd6);
        send_pkt(PE3, 8'd7);
        checks++;
        if (mp_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_req: req=%b required 1", mp_req_valid);
        end
        mp_req_ready = 1'b1;
        @(negedge clk);
        mp_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mp_rsp_valid = 1'b1; mp_rsp_data = 8'd99;
        @(negedge clk);
        mp_rsp_valid = 1'b0;
        pkt_src = PE1;
        #1;
        checks++;
        if (add_valid !== 1'b0 || mp_req_valid !== 1'b0 || pkt_ready !== 1'b1 || add_pos !== 2'd0
            || add_first !== 1'b1 || add_mp !== 8'd0) begin
            errors++;
            $display("FAIL rst_late_rsp: v=%b req=%b rdy=%b pos=%0d first=%b mp=%0d required 0 0 1 0 1 0",
                     add_valid, mp_req_valid, pkt_ready, add_pos, add_first, add_mp);
        end
        @(negedge clk);
        send_pkt(PE1, 8'd1);
        send_pkt(PE2, 8'd2);
        send_pkt(PE3, 8'd3);
        checks++;
        if (add_valid !== 1'b1 || add_mp !== 8'd0 || add_psum !== {8'd3, 8'd2, 8'd1}) begin
            errors++;
            $display("FAIL rst_restart: v=%b mp=%0d psum=%h required 1 0 030201", add_valid, add_mp, add_psum);
        end
        do_cmd();
    endtask

    initial begin
        reset        = 1'b1;
        pkt_valid    = 1'b0;
        pkt_src      = PE1;
        pkt_data     = 8'd0;
        mp_req_ready = 1'b0;
        mp_rsp_valid = 1'b0;
        mp_rsp_data  = 8'd0;
        add_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_map0_in_order();
        test_duplicate();
        test_add_stall();
        test_unknown_src();
        test_fetch_delay();
        test_frame();
        test_reset_fetch_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
